// File: rtl/div64_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  localparam int unsigned DIV_W = 64;
  localparam int unsigned CNT_W = $clog2(DIV_W);

  // Quotient reported for a zero divisor
  localparam logic [DIV_W-1:0] DIV_QUOT_DBZ = '1;

endpackage

// File: rtl/div64_seq_sub65.sv
// Combinational W-bit subtractor a - b with borrow out, used for the
// divider's trial step (a + ~b + 1).
module sub65 #(
  parameter int unsigned W = 65
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_sum;

  // Two's-complement subtract; a missing carry out means a < b
  always_comb begin
    w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (W+1)'(1);
    o_diff   = w_sum[W-1:0];
    o_borrow = ~w_sum[W];
  end

endmodule

// File: rtl/div64_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/done handshake; results and div_by_zero hold until the next completion.
module div64_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned           CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_shifted = {r_rem, r_q[WIDTH-1]};

  sub65 #(.W(WIDTH + 1)) u_sub (
    .i_a      (w_shifted),
    .i_b      ({1'b0, r_div}),
    .o_diff   (w_trial),
    .o_borrow (w_borrow)
  );

  // Trial sign bit and borrow both flag shifted < divisor; the extra
  // bit of width keeps them in agreement, so either may veto the subtract.
  always_comb begin
    w_fits     = ~(w_trial[WIDTH] | w_borrow);
    w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    w_q_next   = {r_q[WIDTH-2:0], w_fits};
  end

  // Control FSM, iteration counter, accumulators and registered outputs.
  // Results are written on the edge that enters FINISH so they appear in
  // the same cycle as the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              r_rem   <= '0;
              r_q     <= dividend;
              r_div   <= divisor;
              r_cnt   <= CNT_LAST;
              busy    <= 1'b1;
              r_state <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= FINISH;
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            quotient    <= w_q_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= FINISH;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div64_seq.sv
// Self-checking bench for div64_seq: directed cases plus random operands
// against a plain a/b, a%b reference model.
module tb_div64_seq;
  import div_pkg::*;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  div64_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns in cycle 1
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  // Called in cycle 1 of a division; returns in the done cycle or on timeout
  task automatic wait_done(input logic [W-1:0] hq, input logic [W-1:0] hr,
                           output int lat, output bit busy_ok, output bit hold_ok);
    lat = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (quotient !== hq || remainder !== hr) hold_ok = 1'b0;
      cyc();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, lat;
    bit           busy_ok, hold_ok;
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; elat = int'(W) + 1;
    end
    issue(a, b);
    wait_done(last_q, last_r, lat, busy_ok, hold_ok);
    chk({tag, ".latency"}, W'(lat), W'(elat));
    if (b != '0) chk({tag, ".busy_run"}, W'(busy_ok), W'(1));
    chk({tag, ".hold"}, W'(hold_ok), W'(1));
    chk({tag, ".busy_done"}, W'(busy), W'(0));
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, W'(div_by_zero), W'(ez));
    last_q = eq;
    last_r = er;
    cyc();
    chk({tag, ".done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    int lat;
    bit busy_ok, hold_ok, quiet;
    logic [W-1:0] a, b;

    // Reset state
    #2;
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    chk("rst.quotient", quotient, '0);
    chk("rst.remainder", remainder, '0);
    chk("rst.dbz", W'(div_by_zero), W'(0));
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    run("basic", 64'd100, 64'd7);
    run("dbz", 64'd1234, 64'd0);
    run("after_dbz", 64'd9, 64'd3);
    run("dbz2", 64'd77, 64'd0);

    // Abort a run with reset at cycle 20
    issue(64'd100, 64'd7);
    repeat (19) cyc();
    rst = 1'b1;
    #1;
    chk("abort.busy", W'(busy), W'(0));
    chk("abort.done", W'(done), W'(0));
    chk("abort.quotient", quotient, '0);
    chk("abort.remainder", remainder, '0);
    chk("abort.dbz", W'(div_by_zero), W'(0));
    cyc(); cyc();
    rst = 1'b0;
    quiet = 1'b1;
    repeat (70) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      cyc();
    end
    chk("abort.no_done", W'(quiet), W'(1));
    last_q = '0;
    last_r = '0;
    run("post_abort", 64'd100, 64'd7);

    // Edge operands
    run("max_by_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run("small", 64'd5, 64'd9);
    run("msb_by_max", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run("zero_num", 64'd0, 64'd12345);
    run("max_by_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Handshake: starts while busy and during done are ignored
    issue(64'd1000, 64'd33);
    repeat (9) cyc();
    dividend = 64'd77; divisor = 64'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    lat = 11;
    while (done !== 1'b1 && lat < 200) begin
      cyc();
      lat++;
    end
    chk("hs.latency", W'(lat), W'(65));
    chk("hs.quotient", quotient, 64'd1000 / 64'd33);
    chk("hs.remainder", remainder, 64'd1000 % 64'd33);
    dividend = 64'd55; divisor = 64'd6; start = 1'b1;
    cyc();
    chk("hs.ignored_done", W'(done), W'(0));
    chk("hs.ignored_busy", W'(busy), W'(0));
    chk("hs.ignored_q", quotient, 64'd1000 / 64'd33);
    cyc();
    start = 1'b0;
    chk("hs.accepted", W'(busy), W'(1));
    wait_done(64'd1000 / 64'd33, 64'd1000 % 64'd33, lat, busy_ok, hold_ok);
    chk("hs2.latency", W'(lat), W'(65));
    chk("hs2.hold", W'(hold_ok), W'(1));
    chk("hs2.quotient", quotient, 64'd55 / 64'd6);
    chk("hs2.remainder", remainder, 64'd55 % 64'd6);
    last_q = 64'd55 / 64'd6;
    last_r = 64'd55 % 64'd6;
    cyc();

    // Random operands with a spread of divisor magnitudes
    for (int unsigned n = 0; n < 500; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b = b >> $urandom_range(0, 63);
      if (n % 7 == 3) a = a >> $urandom_range(0, 63);
      if (b == '0) b = 64'd1;
      run("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
